// File: rtl/pipe_issue_ctrl_if.sv
// Decode-to-execute issue bus: decode instruction fields in, issue/hazard
// and writeback sequencing out.
interface pipe_issue_ctrl_if #(
    parameter int NREG = 8,
    parameter int RW   = 3,
    parameter int LATW = 3
);
    logic            id_valid;
    logic [RW-1:0]   id_rs1;
    logic [RW-1:0]   id_rs2;
    logic [RW-1:0]   id_rd;
    logic            id_wr;
    logic [LATW-1:0] id_lat;
    logic            ex_br_taken;
    logic            issue;
    logic            stall;
    logic            flush;
    logic            ex_busy;
    logic            wb_valid;
    logic [RW-1:0]   wb_rd;
    logic            wb_wr;
    logic [NREG-1:0] pend;
    logic [15:0]     stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_wr, id_lat, ex_br_taken,
        input  issue, stall, flush, ex_busy, wb_valid, wb_rd, wb_wr, pend, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_wr, id_lat, ex_br_taken,
        output issue, stall, flush, ex_busy, wb_valid, wb_rd, wb_wr, pend, stall_cnt
    );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// Issue/hazard controller for the shared multi-cycle execute unit: scoreboard,
// latency down-counter, and stall/flush/writeback sequencing.
//
//   state  | meaning
//   IDLE   | execute unit empty
//   EXEC   | counting execute latency
//   WB     | single writeback cycle, new issue allowed
module pipe_issue_ctrl #(
    parameter int NREG = 8,
    parameter int RW   = 3,
    parameter int LATW = 3
) (
    input  logic             clk,
    input  logic             reset,
    pipe_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    localparam logic [LATW-1:0] LAT_ONE = {{(LATW-1){1'b0}}, 1'b1};

    state_t          state_q;
    logic [LATW-1:0] cnt_q;
    logic [RW-1:0]   rd_q;
    logic            wr_q;
    logic            ex_busy_q;
    logic            wb_valid_q;
    logic [RW-1:0]   wb_rd_q;
    logic            wb_wr_q;
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [15:0]     stall_cnt_q;

    logic            raw;
    logic            waw;
    logic            issue;
    logic            stall;
    logic            flush;
    logic [LATW-1:0] lat_eff;

    assign raw     = pend_q[bus.id_rs1] | pend_q[bus.id_rs2];
    assign waw     = bus.id_wr & pend_q[bus.id_rd];
    assign flush   = bus.ex_br_taken;
    assign issue   = bus.id_valid & ~ex_busy_q & ~raw & ~waw & ~flush;
    assign stall   = bus.id_valid & ~issue & ~flush;
    assign lat_eff = (bus.id_lat == '0) ? LAT_ONE : bus.id_lat;

    // WAW blocks issue on a pending register, so clear and set never collide
    always_comb begin
        pend_d = pend_q;
        if (state_q == S_WB && wb_wr_q)
            pend_d[wb_rd_q] = 1'b0;
        if (issue && bus.id_wr)
            pend_d[bus.id_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= 1'b0;
            ex_busy_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_wr_q     <= 1'b0;
            pend_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (stall && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;

            case (state_q)
                S_IDLE, S_WB: begin
                    wb_valid_q <= 1'b0;
                    wb_rd_q    <= '0;
                    wb_wr_q    <= 1'b0;
                    if (issue) begin
                        state_q   <= S_EXEC;
                        cnt_q     <= lat_eff;
                        rd_q      <= bus.id_rd;
                        wr_q      <= bus.id_wr;
                        ex_busy_q <= 1'b1;
                    end else begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        ex_busy_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == LAT_ONE) begin
                        state_q    <= S_WB;
                        cnt_q      <= '0;
                        ex_busy_q  <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_wr_q    <= wr_q;
                    end else begin
                        cnt_q <= cnt_q - LAT_ONE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    cnt_q      <= '0;
                    ex_busy_q  <= 1'b0;
                    wb_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.issue     = issue;
    assign bus.stall     = stall;
    assign bus.flush     = flush;
    assign bus.ex_busy   = ex_busy_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_wr     = wb_wr_q;
    assign bus.pend      = pend_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed-vector bench for pipe_issue_ctrl; expected values are hand-derived
// from the issue/EXEC/WB cycle timing.
module tb_pipe_issue_ctrl;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    pipe_issue_ctrl_if #(.NREG(8), .RW(3), .LATW(3)) bus ();

    pipe_issue_ctrl #(.NREG(8), .RW(3), .LATW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic wr, input logic [2:0] lat,
                         input logic br);
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_wr       = wr;
        bus.id_lat      = lat;
        bus.ex_br_taken = br;
        #1;
    endtask

    task automatic idle_in();
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        idle_in();
        tick();
        tick();
        reset = 1'b0;

        check_val("rst_ex_busy", 32'(bus.ex_busy), 32'd0);
        check_val("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check_val("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        check_val("rst_pend", 32'(bus.pend), 32'h00);
        check_val("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check_val("rst_issue", 32'(bus.issue), 32'd0);

        // Basic: rd=3, lat=3 issued in cycle 0
        drive(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 3'd3, 1'b0);
        check_val("b_issue", 32'(bus.issue), 32'd1);
        check_val("b_stall", 32'(bus.stall), 32'd0);
        tick();
        idle_in();
        for (int c = 1; c <= 3; c++) begin
            check_val("b_busy", 32'(bus.ex_busy), 32'd1);
            check_val("b_pend", 32'(bus.pend), 32'h08);
            check_val("b_nowb", 32'(bus.wb_valid), 32'd0);
            tick();
        end
        check_val("b_wb_valid", 32'(bus.wb_valid), 32'd1);
        check_val("b_wb_rd", 32'(bus.wb_rd), 32'd3);
        check_val("b_wb_wr", 32'(bus.wb_wr), 32'd1);
        check_val("b_wb_busy", 32'(bus.ex_busy), 32'd0);
        check_val("b_wb_pend", 32'(bus.pend), 32'h08);
        tick();
        check_val("b_post_wb", 32'(bus.wb_valid), 32'd0);
        check_val("b_post_pend", 32'(bus.pend), 32'h00);

        // RAW: A writes r3 lat=2, B reads r3
        drive(1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 3'd2, 1'b0);
        check_val("raw_a_issue", 32'(bus.issue), 32'd1);
        tick();
        drive(1'b1, 3'd3, 3'd0, 3'd4, 1'b1, 3'd1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            check_val("raw_stall", 32'(bus.stall), 32'd1);
            check_val("raw_noissue", 32'(bus.issue), 32'd0);
            tick();
        end
        check_val("raw_b_issue", 32'(bus.issue), 32'd1);
        check_val("raw_b_stall", 32'(bus.stall), 32'd0);
        check_val("raw_stall_cnt", 32'(bus.stall_cnt), 32'd3);
        tick();
        idle_in();
        check_val("raw_b_pend", 32'(bus.pend), 32'h10);
        tick();
        check_val("raw_b_wb_rd", 32'(bus.wb_rd), 32'd4);
        tick();

        // Structural: A rd=1 lat=2, independent B lat=4 waits for A's WB
        drive(1'b1, 3'd0, 3'd0, 3'd1, 1'b1, 3'd2, 1'b0);
        check_val("st_a_issue", 32'(bus.issue), 32'd1);
        tick();
        drive(1'b1, 3'd5, 3'd6, 3'd2, 1'b1, 3'd4, 1'b0);
        check_val("st_stall1", 32'(bus.stall), 32'd1);
        tick();
        check_val("st_stall2", 32'(bus.stall), 32'd1);
        tick();
        check_val("st_wb_valid", 32'(bus.wb_valid), 32'd1);
        check_val("st_b_issue_wb", 32'(bus.issue), 32'd1);
        tick();
        idle_in();
        check_val("st_nogap_busy", 32'(bus.ex_busy), 32'd1);
        check_val("st_pend", 32'(bus.pend), 32'h04);
        check_val("st_stall_cnt", 32'(bus.stall_cnt), 32'd5);
        for (int c = 0; c < 4; c++) tick();
        check_val("st_b_wb_rd", 32'(bus.wb_rd), 32'd2);
        tick();
        check_val("st_pend_clr", 32'(bus.pend), 32'h00);

        // Flush: in-flight op keeps its writeback, no issue under flush
        drive(1'b1, 3'd0, 3'd0, 3'd5, 1'b1, 3'd2, 1'b0);
        check_val("fl_a_issue", 32'(bus.issue), 32'd1);
        tick();
        drive(1'b1, 3'd1, 3'd2, 3'd6, 1'b1, 3'd1, 1'b1);
        check_val("fl_flush", 32'(bus.flush), 32'd1);
        check_val("fl_stall", 32'(bus.stall), 32'd0);
        tick();
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1);
        check_val("fl_novalid_flush", 32'(bus.flush), 32'd1);
        check_val("fl_novalid_stall", 32'(bus.stall), 32'd0);
        tick();
        idle_in();
        check_val("fl_wb_valid", 32'(bus.wb_valid), 32'd1);
        check_val("fl_wb_rd", 32'(bus.wb_rd), 32'd5);
        tick();
        drive(1'b1, 3'd1, 3'd2, 3'd6, 1'b1, 3'd1, 1'b1);
        check_val("fl_idle_issue", 32'(bus.issue), 32'd0);
        check_val("fl_idle_flush", 32'(bus.flush), 32'd1);
        check_val("fl_idle_stall", 32'(bus.stall), 32'd0);
        tick();
        idle_in();
        check_val("fl_no_exec", 32'(bus.ex_busy), 32'd0);
        check_val("fl_stall_cnt", 32'(bus.stall_cnt), 32'd5);

        // lat=0 behaves as 1; rd=0 never becomes pending
        drive(1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0);
        check_val("z_issue", 32'(bus.issue), 32'd1);
        tick();
        idle_in();
        check_val("z_busy", 32'(bus.ex_busy), 32'd1);
        check_val("z_pend", 32'(bus.pend), 32'h00);
        tick();
        check_val("z_wb_valid", 32'(bus.wb_valid), 32'd1);
        check_val("z_wb_busy", 32'(bus.ex_busy), 32'd0);
        tick();
        check_val("z_done", 32'(bus.wb_valid), 32'd0);

        // Reset during EXEC drops the op
        drive(1'b1, 3'd0, 3'd0, 3'd6, 1'b1, 3'd3, 1'b0);
        tick();
        idle_in();
        check_val("r_busy", 32'(bus.ex_busy), 32'd1);
        check_val("r_pend", 32'(bus.pend), 32'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("r_ex_busy", 32'(bus.ex_busy), 32'd0);
        check_val("r_pend0", 32'(bus.pend), 32'h00);
        check_val("r_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check_val("r_wb_valid", 32'(bus.wb_valid), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("r_no_wb", 32'(bus.wb_valid), 32'd0);
        end

        // Saturation: self-dependent lat=7 stream stalls 8 of every 9 cycles
        drive(1'b1, 3'd7, 3'd0, 3'd7, 1'b1, 3'd7, 1'b0);
        for (int c = 0; c < 76000; c++) tick();
        check_val("sat_stall_cnt", 32'(bus.stall_cnt), 32'h0000FFFF);
        tick();
        tick();
        check_val("sat_hold", 32'(bus.stall_cnt), 32'h0000FFFF);
        idle_in();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_issue_ctrl.md
# pipe_issue_ctrl

Issue and hazard controller for the multi-cycle execute stage of the pipelined processor (`maincode`). It decides each cycle whether the instruction held in decode may advance into the shared multi-cycle execute unit. It tracks outstanding destination registers in a scoreboard, counts execute latency, and produces stall, flush and writeback-sequencing signals for the datapath.

## Interface
- `NREG`, 8, number of architectural registers; register 0 is hardwired zero
- `RW`, 3, register address width (log2 NREG)
- `LATW`, 3, width of execute latency field

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `id_valid`  in  1  decode holds a valid instruction
- `id_rs1`, `id_rs2`  in  RW  source registers
- `id_rd`  in  RW  destination register
- `id_wr`  in  1  instruction writes `id_rd`
- `id_lat`  in  LATW  execute cycles required; 0 treated as 1
- `ex_br_taken`  in  1  execute resolved a taken branch this cycle
- `issue`  out  1  decode instruction advances into execute at the coming edge (combinational)
- `stall`  out  1  hold fetch/decode registers (combinational)
- `flush`  out  1  squash decode contents (combinational)
- `ex_busy`  out  1  execute unit occupied (registered)
- `wb_valid`  out  1  writeback cycle of the in-flight instruction (registered)
- `wb_rd`  out  RW  destination being written back
- `wb_wr`  out  1  writeback writes a register
- `pend`  out  NREG  scoreboard, bit i = register i has a pending write
- `stall_cnt`  out  16  saturating count of stalled cycles

## Operation
- FSM states:
  - IDLE: unit empty.
  - EXEC: counting latency.
  - WB: one writeback cycle.
- `ex_busy` = (state == EXEC).
- Hazard conditions:
  - RAW: `pend[id_rs1]` or `pend[id_rs2]`.
  - WAW: `id_wr` and `pend[id_rd]`.
  - `pend[0]` is always 0.
- `issue` = `id_valid` & !`ex_busy` & !RAW & !WAW & !`ex_br_taken`.
- `flush` = `ex_br_taken`. Flush has priority: no issue in a flush cycle. The in-flight execute instruction is older and is not cancelled.
- `stall` = `id_valid` & !`issue` & !`flush`.
- On issue:
  - state goes to EXEC.
  - `cnt` is loaded with max(`id_lat`, 1).
  - `id_rd`/`id_wr` are latched.
  - `pend[id_rd]` is set if `id_wr` and `id_rd` != 0.
- EXEC: if `cnt` == 1, go to WB; otherwise decrement `cnt`.
- WB:
  - `wb_valid`=1; `wb_rd`/`wb_wr` are driven from the latched values.
  - At the end of the cycle, `pend[wb_rd]` is cleared.
  - A new issue is allowed in WB. It goes to EXEC, or to IDLE if there is no issue.
- Same-edge set/clear on the same register is impossible, because WAW blocks issue while the bit is pending.
- No forwarding: a dependent instruction cannot issue in the WB cycle. It issues in the cycle after, once the pend bit reads 0.
- `stall_cnt` increments on every cycle with `stall`=1 and saturates at 0xFFFF.

## Timing
- Reset (sampled at edge) sets:
  - state IDLE, `cnt`=0, `pend`=0
  - `wb_valid`=0, `wb_rd`=0, `wb_wr`=0
  - `ex_busy`=0, `stall_cnt`=0
- Reset mid-EXEC drops the in-flight op; no writeback is produced.
- Issue at edge E0 gives:
  - `ex_busy`=1 for cycles E0+1 … E0+L
  - `wb_valid`=1 in cycle E0+L+1
  - `pend` bit clear from cycle E0+L+2
- L=1: EXEC for one cycle, then WB.
- Back-to-back independent instructions: the next issue occurs in the WB cycle, so throughput is one instruction per L+1 cycles.
- `issue`, `stall` and `flush` settle combinationally in the same cycle as their inputs. All other outputs are registered.
- `ex_br_taken` together with `id_valid`=0 gives `flush`=1, `stall`=0.

## Test plan
- Reset, then `id_valid`=1, rs1=1, rs2=2, rd=3, wr=1, lat=3 → `issue`=1 in cycle 0; `ex_busy` high in cycles 1–3; `wb_valid`=1, `wb_rd`=3 in cycle 4; `pend`=8'h08 in cycles 1–4, then 0.
- RAW: instruction A writes r3 with lat=2; next instruction B reads rs1=3 → `stall`=1 from the cycle after A issues through A's WB cycle; B issues the cycle after WB; `stall_cnt`=3.
- Structural/WAW: B is independent but has lat=4 while A (lat=2) executes → B stalls until A's WB cycle, where `issue`=1; `ex_busy` stays high with no idle gap.
- Flush: `ex_br_taken`=1 in the same cycle as a hazard-free `id_valid` → `flush`=1, `issue`=0, `stall`=0; the in-flight instruction still writes back on schedule.
- Edge cases:
  - `id_lat`=0 → behaves as 1.
  - rd=0 with wr=1 → `pend` stays 0.
  - Reset asserted during EXEC → no `wb_valid`, all outputs return to reset values next cycle.
- Saturation: hold a permanent RAW stall for 70000 cycles → `stall_cnt` = 0xFFFF, with no wrap.
